// File: rtl/instruction_queue.sv
// -----------------------------------------------------------------------------
// instruction_queue
//
// DEPTH-entry FIFO between instruction fetch and decode. Each entry holds an
// instruction word and the PC it was fetched from. Fetch pushes through a
// valid/ready handshake, and decode pops the same way. Decode can stall the
// head entry in place. A flush discards everything for branch and exception
// redirects.
//
// Ports
//   clock      in   system clock, rising edge
//   nreset     in   synchronous active-low reset (overrides everything)
//   flush      in   discard all entries; same-cycle push/pop are dropped
//   stall      in   decode stall; head entry is held while high
//   in_valid   in   fetch presents {in_instr, in_pc}
//   in_ready   out  queue can accept a word (== !full)
//   in_instr   in   fetched instruction word
//   in_pc      in   PC of the fetched word
//   out_valid  out  head entry valid (== !empty)
//   out_ready  in   decode accepts the head entry
//   out_instr  out  head instruction word, 0 when empty
//   out_pc     out  head PC, 0 when empty
//   count      out  occupancy 0..DEPTH
//   full       out  count == DEPTH
//   empty      out  count == 0
// -----------------------------------------------------------------------------
module instruction_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4,
    localparam int CNT_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic                  clock,
    input  logic                  nreset,
    input  logic                  flush,
    input  logic                  stall,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_instr,
    input  logic [ADDR_WIDTH-1:0] in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  full,
    output logic                  empty
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] instr;
        logic [ADDR_WIDTH-1:0] pc;
    } entry_t;

    entry_t               mem_q [DEPTH];
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CNT_WIDTH-1:0] count_q,  count_d;

    logic push, pop;

    // ------------------------------------------------------------------
    // Status and handshakes come from registered state only, so there is
    // no combinational path from out_ready back to in_ready.
    // ------------------------------------------------------------------
    assign full      = (count_q == CNT_WIDTH'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign in_ready  = !full;
    assign out_valid = !empty;

    // Empty reads as a NOP with PC 0 rather than exposing stale storage.
    assign out_instr = empty ? '0 : mem_q[rd_ptr_q].instr;
    assign out_pc    = empty ? '0 : mem_q[rd_ptr_q].pc;

    // flush cancels both sides of the handshake in the same cycle.
    assign push = in_valid  && in_ready  && !flush;
    assign pop  = out_valid && out_ready && !stall && !flush;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers are exactly log2(DEPTH) bits, so +1 wraps modulo DEPTH.
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_WIDTH'(1);
                2'b01:   count_d = count_q - CNT_WIDTH'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!nreset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is cleared on reset so that no output can ever carry X.
    // A flush only moves the pointers; stale words are unreachable.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= '{instr: in_instr, pc: in_pc};
        end
    end

endmodule

// File: tb/tb_instruction_queue.sv
// -----------------------------------------------------------------------------
// tb_instruction_queue
//
// Drives directed and random traffic into instruction_queue. The reference is
// a plain queue of {instr, pc} entries with a bounded size of DEPTH. After
// each rising edge, every output is compared against the reference.
// -----------------------------------------------------------------------------
module tb_instruction_queue;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clock;
    logic          nreset;
    logic          flush;
    logic          stall;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_instr;
    logic [AW-1:0] in_pc;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_instr;
    logic [AW-1:0] out_pc;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;

    instruction_queue #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH     (DEPTH)
    ) dut (
        .clock    (clock),
        .nreset   (nreset),
        .flush    (flush),
        .stall    (stall),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_instr (in_instr),
        .in_pc    (in_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_pc   (out_pc),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [DW-1:0] instr;
        logic [AW-1:0] pc;
    } ent_t;

    ent_t mq[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int n;
        n = mq.size();
        chk("count",     64'(count),     64'(n));
        chk("empty",     64'(empty),     64'(n == 0));
        chk("full",      64'(full),      64'(n == DEPTH));
        chk("in_ready",  64'(in_ready),  64'(n < DEPTH));
        chk("out_valid", 64'(out_valid), 64'(n > 0));
        chk("out_instr", 64'(out_instr), (n > 0) ? 64'(mq[0].instr) : 64'd0);
        chk("out_pc",    64'(out_pc),    (n > 0) ? 64'(mq[0].pc)    : 64'd0);
    endtask

    // One clock: decide the handshakes from the reference state and the
    // current inputs, let the edge happen, update the reference, then compare.
    task automatic step();
        bit   push_ok, pop_ok;
        ent_t e;
        push_ok = in_valid && (mq.size() < DEPTH) && !flush;
        pop_ok  = out_ready && !stall && !flush && (mq.size() > 0);
        e.instr = in_instr;
        e.pc    = in_pc;
        @(posedge clock);
        #1;
        if (!nreset || flush) begin
            mq.delete();
        end else begin
            if (pop_ok)  void'(mq.pop_front());
            if (push_ok) mq.push_back(e);
        end
        check_outputs();
    endtask

    task automatic drive(input logic nr, input logic fl, input logic st,
                         input logic iv, input logic [DW-1:0] ii,
                         input logic [AW-1:0] ip, input logic ordy);
        nreset    = nr;
        flush     = fl;
        stall     = st;
        in_valid  = iv;
        in_instr  = ii;
        in_pc     = ip;
        out_ready = ordy;
        step();
    endtask

    initial begin
        logic [DW-1:0] w;
        nreset    = 1'b0;
        flush     = 1'b0;
        stall     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        out_ready = 1'b0;

        // Reset held for two cycles, then idle.
        drive(0, 0, 0, 0, '0, '0, 0);
        drive(0, 0, 0, 0, '0, '0, 0);
        drive(1, 0, 0, 0, '0, '0, 0);

        // Fill to full with decode not ready; the fifth push is dropped.
        for (int i = 0; i < 4; i++)
            drive(1, 0, 0, 1, 32'h11111111 * (i + 1), 32'h100 + 4 * i, 0);
        drive(1, 0, 0, 1, 32'h55555555, 32'h110, 0);
        // Drain in order.
        for (int i = 0; i < 5; i++) drive(1, 0, 0, 0, '0, '0, 1);

        // Stall holds the head entry for three cycles.
        drive(1, 0, 0, 1, 32'hA0000001, 32'h300, 0);
        drive(1, 0, 0, 1, 32'hA0000002, 32'h304, 0);
        for (int i = 0; i < 3; i++) drive(1, 0, 1, 0, '0, '0, 1);
        drive(1, 0, 0, 0, '0, '0, 1);
        drive(1, 0, 0, 0, '0, '0, 1);

        // Sustained simultaneous push and pop at count 2; pointers wrap.
        drive(1, 0, 0, 1, 32'hB0000000, 32'h400, 0);
        drive(1, 0, 0, 1, 32'hB0000001, 32'h404, 0);
        for (int i = 2; i < 12; i++)
            drive(1, 0, 0, 1, 32'hB0000000 + i, 32'h400 + 4 * i, 1);
        drive(1, 0, 0, 0, '0, '0, 1);
        drive(1, 0, 0, 0, '0, '0, 1);

        // Flush at count 3 with both handshakes offered.
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 1, 32'hC0000000 + i, 32'h500 + 4 * i, 0);
        drive(1, 1, 0, 1, 32'hCCCCCCCC, 32'h5FC, 1);
        drive(1, 0, 0, 1, 32'hDEADBEEF, 32'h200, 0);
        drive(1, 0, 0, 0, '0, '0, 1);

        // Reset mid-operation with a push pending.
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 1, 32'hE0000000 + i, 32'h600 + 4 * i, 0);
        drive(0, 0, 0, 1, 32'hEEEEEEEE, 32'h6FC, 1);
        drive(1, 0, 0, 1, 32'hF0000000, 32'h700, 0);
        drive(1, 0, 0, 1, 32'hF0000001, 32'h704, 1);
        drive(1, 0, 0, 0, '0, '0, 1);
        drive(1, 0, 0, 0, '0, '0, 1);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 3000; i++) begin
            w = $urandom;
            drive(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 2) != 0),
                  w,
                  $urandom,
                  ($urandom_range(0, 2) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_queue.md
Name: instruction_queue

Overview:
Parametrised instruction buffer that sits between instruction fetch and decode. It replaces the single-entry instruction register with a DEPTH-entry FIFO of instruction words, each tagged with its fetch PC. Fetch pushes and decode pops through valid/ready handshakes. It supports a decode-side stall and a pipeline flush for branch redirects. Everything is clocked on the rising edge of one clock.

Parameters:
DATA_WIDTH, 32, instruction word width in bits.
ADDR_WIDTH, 32, PC tag width in bits.
DEPTH, 4, number of entries; must be a power of 2 and at least 2.
CNT_WIDTH, clog2(DEPTH)+1, local parameter; width of the occupancy count (not overridable).

Ports:
clock  input  1  system clock; all state changes on the rising edge.
nreset  input  1  reset; synchronous and active-low.
flush  input  1  discard all entries (branch/exception redirect).
stall  input  1  decode stall; blocks pop while high.
in_valid  input  1  fetch presents a word.
in_ready  output  1  queue can accept a word.
in_instr  input  DATA_WIDTH  fetched instruction word.
in_pc  input  ADDR_WIDTH  PC of the fetched word.
out_valid  output  1  head entry is valid.
out_ready  input  1  decode accepts the head entry.
out_instr  output  DATA_WIDTH  head instruction word; 0 (NOP) when empty.
out_pc  output  ADDR_WIDTH  head PC; 0 when empty.
count  output  CNT_WIDTH  current occupancy, 0..DEPTH.
full  output  1  count == DEPTH.
empty  output  1  count == 0.

Behaviour:
- Reset (nreset==0 at a rising edge):
  - rd_ptr, wr_ptr, count and all storage go to 0.
  - Next cycle: out_valid=0, out_instr=0, out_pc=0, empty=1, full=0, in_ready=1.
  - Reset overrides flush, push and pop.
- Handshake signals (all combinational from registered state only):
  - in_ready = !full. There is no ready-when-popping-while-full path.
  - out_valid = !empty.
  - out_instr and out_pc = storage at rd_ptr when !empty, else 0.
- Push: occurs when in_valid && in_ready && !flush.
  - Writes {in_instr, in_pc} to wr_ptr.
  - wr_ptr increments modulo DEPTH.
- Pop: occurs when out_valid && out_ready && !stall && !flush.
  - rd_ptr increments modulo DEPTH.
  - stall high holds the head entry unchanged regardless of out_ready.
- count update: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- Simultaneous push and pop:
  - Legal whenever 0 < count < DEPTH; count is unchanged.
  - When full, only the pop can happen (in_ready=0).
  - When empty, only the push can happen (out_valid=0).
- Latency and bypass:
  - No bypass. A word pushed at edge N is visible on out_* with out_valid=1 in the cycle after edge N.
  - Minimum fetch-to-decode latency is 1 cycle.
- Flush (nreset==1, flush==1 at an edge):
  - rd_ptr, wr_ptr and count go to 0.
  - Any push or pop in the same cycle is discarded; storage contents need not be cleared.
  - Next cycle: empty=1, out_instr=0, out_pc=0.
- Pointer wrap: pointers are clog2(DEPTH) bits and wrap naturally. Full and empty are derived from count, not from pointer compare.
- Inputs ignored when their handshake is not taken:
  - in_instr and in_pc when no push.
  - out_ready when stall=1 or empty.
- Reset mid-operation (any occupancy) behaves exactly as the reset rule above. The first push after reset lands at entry 0.
- No X propagation: every output is driven from reset state onward.

Test Plan:
- Reset then idle: nreset=0 for 2 cycles -> count=0, empty=1, in_ready=1, out_valid=0, out_instr=0, out_pc=0.
- Fill and drain, DEPTH=4, out_ready=0:
  - Push 0x11111111..0x44444444 with pc 0x100..0x10C -> full=1, in_ready=0, count=4.
  - A 5th push (0x55555555) is dropped.
  - Then out_ready=1 -> pops in order 0x111..,0x222..,0x333..,0x444.. with matching pc; empty=1 after the 4th pop.
- Stall: with 2 entries queued, stall=1 and out_ready=1 for 3 cycles -> out_instr holds the first word and count stays 2; stall=0 -> pops resume.
- Simultaneous push/pop at count=2, sustained for 10 cycles -> count stays 2; output order is strictly FIFO and rd_ptr and wr_ptr wrap past 3 to 0 without loss.
- Flush:
  - With count=3, assert flush together with in_valid=1 and out_ready=1 -> next cycle count=0, empty=1, out_instr=0.
  - Next push 0xDEADBEEF, pc 0x200 appears at the output one cycle later.
- Reset mid-operation: with count=3 and a push pending, pulse nreset=0 for 1 cycle -> count=0, outputs 0; subsequent push/pop traffic is correct from entry 0.
